inst_fetch_buffer: RTL and testbench

- Prefetches the instruction stream from HBM in `HBM_WIDTH`-bit beats.
- Unpacks each beat into `INST_WIDTH`-bit instructions and buffers them in a FIFO.
- Presents instructions one at a time to the decoder over a valid/ready handshake.
- Sits directly upstream of instruction decode, between the HBM read port and the decoder.

---
 rtl/inst_fetch_buffer.sv | 217 +++++++++++++++++++++
 tb/tb_inst_fetch_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// Instruction prefetch buffer: pulls HBM beats, unpacks them into instructions, feeds the decoder.
// Latency: first request the cycle after start; a beat written at edge N is visible as inst_valid from N+1.
// Backpressure: requests are issued only when FIFO space for a whole beat is reserved; decoder stalls via inst_ready.
// Optional feature macro: INST_BUFF_PERF_EN adds a saturating stall_cycles counter output.
module inst_fetch_buffer #(
  parameter int INST_WIDTH     = 32,
  parameter int HBM_WIDTH      = 512,
  parameter int HBM_ADDR_WIDTH = 128,
  parameter int DEPTH          = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [HBM_ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]               inst_count,
  input  logic                      flush,
  output logic                      hbm_req_valid,
  input  logic                      hbm_req_ready,
  output logic [HBM_ADDR_WIDTH-1:0] hbm_req_addr,
  input  logic                      hbm_rsp_valid,
  input  logic [HBM_WIDTH-1:0]      hbm_rsp_data,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [INST_WIDTH-1:0]     inst_data,
  output logic                      busy,
`ifdef INST_BUFF_PERF_EN
  output logic [31:0]               stall_cycles,
`endif
  output logic                      done
);

  localparam int IPB      = HBM_WIDTH / INST_WIDTH;
  localparam int LOG2_IPB = $clog2(IPB);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int OUT_W    = $clog2(DEPTH / IPB) + 1;
  localparam int LANE_W   = LOG2_IPB + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [HBM_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                      req_vld_q, req_vld_d;
  logic [31:0]               beats_left_q, beats_left_d;
  logic [31:0]               remaining_q, remaining_d;
  logic [OUT_W-1:0]          outstanding_q, outstanding_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic                      done_q, done_d;
  logic [INST_WIDTH-1:0]     mem_q [DEPTH];

  logic                      req_hs;
  logic                      pop;
  logic                      beat_wr;
  logic                      flush_now;
  logic [LANE_W-1:0]         lanes;
  logic [32:0]               ceil_sum;
  logic [31:0]               reserved;

  assign hbm_req_valid = req_vld_q;
  assign hbm_req_addr  = req_addr_q;
  assign inst_valid    = (count_q != '0);
  assign inst_data     = inst_valid ? mem_q[rd_ptr_q] : '0;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;

  // Next-state, pointer/occupancy bookkeeping and request-valid computation
  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    req_vld_d     = 1'b0;
    beats_left_d  = beats_left_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    done_d        = 1'b0;

    req_hs    = req_vld_q && hbm_req_ready;
    pop       = inst_valid && inst_ready;
    flush_now = flush && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
    ceil_sum  = {1'b0, inst_count} + 33'(IPB - 1);

    // The final beat of a fetch may carry fewer useful lanes than IPB.
    if (remaining_q >= 32'(IPB)) lanes = LANE_W'(IPB);
    else                         lanes = LANE_W'(remaining_q);

    // Beats arriving during or after a flush are dropped but still retire outstanding.
    beat_wr = hbm_rsp_valid && !flush &&
              ((state_q == ST_FETCH) || (state_q == ST_DRAIN));

    if (req_hs) begin
      outstanding_d = outstanding_d + OUT_W'(1);
      req_addr_d    = req_addr_q + HBM_ADDR_WIDTH'(HBM_WIDTH / 8);
      beats_left_d  = beats_left_q - 32'd1;
    end
    if (hbm_rsp_valid && (state_q != ST_IDLE)) begin
      outstanding_d = outstanding_d - OUT_W'(1);
    end

    if (beat_wr) begin
      wr_ptr_d    = wr_ptr_q + PTR_W'(lanes);
      remaining_d = remaining_q - 32'(lanes);
      count_d     = count_d + CNT_W'(lanes);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_d - CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          req_addr_d   = base_addr;
          remaining_d  = inst_count;
          beats_left_d = 32'(ceil_sum >> LOG2_IPB);
          if (inst_count == 32'd0) done_d  = 1'b1;
          else                     state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (flush)                              state_d = ST_FLUSH;
        else if (req_hs && beats_left_q == 32'd1) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end else if (count_d == '0 && outstanding_d == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (outstanding_d == '0) state_d = ST_IDLE;
      end
    endcase

    if (flush_now) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    // Request only when a full beat of space is free after accounting for beats in flight.
    reserved  = 32'(count_d) + 32'(IPB) * 32'(outstanding_d);
    req_vld_d = (state_d == ST_FETCH) && (beats_left_d != 32'd0) &&
                (reserved <= 32'(DEPTH - IPB));
  end

  // Control and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      req_addr_q    <= '0;
      req_vld_q     <= 1'b0;
      beats_left_q  <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      req_vld_q     <= req_vld_d;
      beats_left_q  <= beats_left_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      done_q        <= done_d;
    end
  end

  // FIFO storage: all useful lanes of a beat land in one cycle, lane 0 first
  always_ff @(posedge clk) begin
    if (beat_wr) begin
      for (int i = 0; i < IPB; i++) begin
        if (i < int'(lanes)) begin
          mem_q[wr_ptr_q + PTR_W'(i)] <= hbm_rsp_data[i*INST_WIDTH +: INST_WIDTH];
        end
      end
    end
  end

`ifdef INST_BUFF_PERF_EN
  logic [31:0] stall_q, stall_d;

  assign stall_cycles = stall_q;

  // Count cycles the decoder wanted an instruction but none was buffered
  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && start) begin
      stall_d = '0;
    end else if (busy && inst_ready && !inst_valid && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: single beat, partial tail, space reservation,
// flush with beats in flight, zero-length and ignored start, asynchronous reset.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_inst_fetch_buffer;
  localparam int IW = 32;
  localparam int HW = 512;
  localparam int AW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [31:0]   inst_count = '0;
  logic          flush = 1'b0;
  logic          hbm_req_valid;
  logic          hbm_req_ready = 1'b0;
  logic [AW-1:0] hbm_req_addr;
  logic          hbm_rsp_valid = 1'b0;
  logic [HW-1:0] hbm_rsp_data = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [IW-1:0] inst_data;
  logic          busy;
  logic          done;
`ifdef INST_BUFF_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  inst_fetch_buffer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .inst_count(inst_count), .flush(flush),
    .hbm_req_valid(hbm_req_valid), .hbm_req_ready(hbm_req_ready),
    .hbm_req_addr(hbm_req_addr), .hbm_rsp_valid(hbm_rsp_valid),
    .hbm_rsp_data(hbm_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .busy(busy),
`ifdef INST_BUFF_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HW-1:0] beat(input int b);
    logic [HW-1:0] r;
    r = '0;
    for (int i = 0; i < HW/IW; i++) r[i*IW +: IW] = 32'(b + i);
    return r;
  endfunction

  task automatic send_beat(input int b);
    hbm_rsp_valid = 1'b1;
    hbm_rsp_data  = beat(b);
    tick();
    hbm_rsp_valid = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [31:0] n);
    base_addr  = a;
    inst_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req_valid", AW'(hbm_req_valid), AW'(0));
    chk("rst_req_addr", hbm_req_addr, AW'(0));
    chk("rst_inst_valid", AW'(inst_valid), AW'(0));
    chk("rst_inst_data", AW'(inst_data), AW'(0));
    chk("rst_busy", AW'(busy), AW'(0));
    chk("rst_done", AW'(done), AW'(0));
    #10 rst = 1'b0;
    tick();

    // 1: single full beat
    do_start(AW'(32'h1000), 32'd16);
    chk("t1_req_valid", AW'(hbm_req_valid), AW'(1));
    chk("t1_req_addr", hbm_req_addr, AW'(32'h1000));
    chk("t1_busy", AW'(busy), AW'(1));
    hbm_req_ready = 1'b1;
    tick();
    hbm_req_ready = 1'b0;
    chk("t1_one_req", AW'(hbm_req_valid), AW'(0));
    send_beat(0);
    chk("t1_valid", AW'(inst_valid), AW'(1));
    inst_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t1_data", AW'(inst_data), AW'(k));
      chk("t1_no_early_done", AW'(done), AW'(0));
      tick();
    end
    chk("t1_done", AW'(done), AW'(1));
    chk("t1_busy_low", AW'(busy), AW'(0));
    chk("t1_empty", AW'(inst_valid), AW'(0));
    inst_ready = 1'b0;
    tick();
    chk("t1_done_pulse", AW'(done), AW'(0));

    // 2: partial tail of 4 instructions
    do_start(AW'(32'h1000), 32'd20);
    chk("t2_addr0", hbm_req_addr, AW'(32'h1000));
    hbm_req_ready = 1'b1;
    tick();
    chk("t2_req2_valid", AW'(hbm_req_valid), AW'(1));
    chk("t2_addr1", hbm_req_addr, AW'(32'h1040));
    tick();
    hbm_req_ready = 1'b0;
    chk("t2_two_reqs", AW'(hbm_req_valid), AW'(0));
    send_beat(100);
    send_beat(200);
    inst_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("t2_data", AW'(inst_data), (k < 16) ? AW'(100 + k) : AW'(200 + k - 16));
      tick();
    end
    chk("t2_tail_dropped", AW'(inst_valid), AW'(0));
    chk("t2_done", AW'(done), AW'(1));
    inst_ready = 1'b0;
    tick();

    // 3: backpressure and space reservation
    hbm_req_ready = 1'b1;
    do_start(AW'(32'h8000), 32'd64);
    chk("t3_req1", AW'(hbm_req_valid), AW'(1));
    tick();
    chk("t3_req2", AW'(hbm_req_valid), AW'(1));
    tick();
    chk("t3_no_req3", AW'(hbm_req_valid), AW'(0));
    send_beat(300);
    chk("t3_no_req3_b1", AW'(hbm_req_valid), AW'(0));
    send_beat(400);
    tick();
    chk("t3_no_req3_full", AW'(hbm_req_valid), AW'(0));
    hbm_req_ready = 1'b0;
    inst_ready    = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t3_data", AW'(inst_data), AW'(300 + k));
      chk("t3_hold_req", AW'(hbm_req_valid), AW'(0));
      tick();
    end
    inst_ready = 1'b0;
    chk("t3_req3", AW'(hbm_req_valid), AW'(1));
    chk("t3_req3_addr", hbm_req_addr, AW'(32'h8080));
    chk("t3_head", AW'(inst_data), AW'(400));
    tick();
    chk("t3_req3_held", AW'(hbm_req_valid), AW'(1));
    chk("t3_addr_held", hbm_req_addr, AW'(32'h8080));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_flush_empty", AW'(inst_valid), AW'(0));
    chk("t3_flush_noreq", AW'(hbm_req_valid), AW'(0));
    tick();
    chk("t3_idle", AW'(busy), AW'(0));
    chk("t3_no_done", AW'(done), AW'(0));

    // 4: flush with two beats outstanding
    hbm_req_ready = 1'b1;
    do_start(AW'(32'h9000), 32'd64);
    tick();
    tick();
    hbm_req_ready = 1'b0;
    chk("t4_two_out", AW'(hbm_req_valid), AW'(0));
    flush         = 1'b1;
    hbm_rsp_valid = 1'b1;
    hbm_rsp_data  = beat(800);
    tick();
    flush         = 1'b0;
    hbm_rsp_valid = 1'b0;
    chk("t4_valid_low", AW'(inst_valid), AW'(0));
    chk("t4_flushing", AW'(busy), AW'(1));
    tick();
    chk("t4_wait_out", AW'(busy), AW'(1));
    send_beat(900);
    chk("t4_idle", AW'(busy), AW'(0));
    chk("t4_no_done", AW'(done), AW'(0));
    chk("t4_dropped", AW'(inst_valid), AW'(0));
    do_start(AW'(32'h2000), 32'd16);
    chk("t4_restart_addr", hbm_req_addr, AW'(32'h2000));
    hbm_req_ready = 1'b1;
    tick();
    hbm_req_ready = 1'b0;
    send_beat(500);
    inst_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t4_data", AW'(inst_data), AW'(500 + k));
      tick();
    end
    inst_ready = 1'b0;
    chk("t4_done", AW'(done), AW'(1));
    tick();

    // 5: zero length, then start while busy
    do_start(AW'(32'h7000), 32'd0);
    chk("t5_zero_done", AW'(done), AW'(1));
    chk("t5_zero_noreq", AW'(hbm_req_valid), AW'(0));
    chk("t5_zero_idle", AW'(busy), AW'(0));
    tick();
    do_start(AW'(32'h3000), 32'd16);
    do_start(AW'(32'h4000), 32'd32);
    chk("t5_addr_kept", hbm_req_addr, AW'(32'h3000));
    hbm_req_ready = 1'b1;
    tick();
    hbm_req_ready = 1'b0;
    chk("t5_count_kept", AW'(hbm_req_valid), AW'(0));
    send_beat(600);
    inst_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t5_data", AW'(inst_data), AW'(600 + k));
      tick();
    end
    inst_ready = 1'b0;
    chk("t5_done", AW'(done), AW'(1));
    tick();

    // 6: asynchronous reset while draining
    do_start(AW'(32'h5000), 32'd16);
    hbm_req_ready = 1'b1;
    tick();
    hbm_req_ready = 1'b0;
    send_beat(700);
    chk("t6_pre_valid", AW'(inst_valid), AW'(1));
    #3 rst = 1'b1;
    #1;
    chk("t6_req_valid", AW'(hbm_req_valid), AW'(0));
    chk("t6_req_addr", hbm_req_addr, AW'(0));
    chk("t6_inst_valid", AW'(inst_valid), AW'(0));
    chk("t6_inst_data", AW'(inst_data), AW'(0));
    chk("t6_busy", AW'(busy), AW'(0));
    chk("t6_done", AW'(done), AW'(0));
    #2 rst = 1'b0;
    tick();
    chk("t6_idle", AW'(busy), AW'(0));
    do_start(AW'(32'h5000), 32'd0);
    chk("t6_restart_done", AW'(done), AW'(1));
    tick();

`ifdef INST_BUFF_PERF_EN
    // Stall counter: decoder ready from start, first instruction two cycles later
    inst_ready = 1'b1;
    do_start(AW'(32'h6000), 32'd16);
    hbm_req_ready = 1'b1;
    tick();
    hbm_req_ready = 1'b0;
    send_beat(0);
    chk("perf_valid", AW'(inst_valid), AW'(1));
    chk("perf_stalls", AW'(stall_cycles), AW'(2));
    for (int k = 0; k < 16; k++) tick();
    inst_ready = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
